// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, the operation codes driven by the ALU
// controller, and the execute-stage FSM states.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_EQ   = 4'b1000,
        OP_NE   = 4'b1001,
        OP_GE   = 4'b1010,
        OP_LT   = 4'b1011,
        OP_SLT  = 4'b1100,
        OP_ADDI = 4'b1101,
        OP_SLTI = 4'b1110,
        OP_RSVD = 4'b1111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } ex_state_t;

    function automatic logic op_is_shift(input alu_op_t op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative shifter: moves the operand at most SHIFT_STEP bits per cycle.
// done/result are valid in the cycle whose edge performs the final step.
module alu_shift_iter #(
    parameter int XLEN       = alu_pkg::XLEN,
    parameter int SHIFT_STEP = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    kill,
    input  logic                    start,
    input  logic                    dir,
    input  logic                    arith,
    input  logic [XLEN-1:0]         data,
    input  logic [$clog2(XLEN)-1:0] shamt,
    output logic                    busy,
    output logic                    done,
    output logic [XLEN-1:0]         result
);

    localparam int           SHW  = $clog2(XLEN);
    localparam logic [SHW:0] STEP = (SHW + 1)'(SHIFT_STEP);

    logic [XLEN-1:0] r_data;
    logic [SHW:0]    r_rem;
    logic            r_busy;
    logic            r_dir;
    logic            r_arith;

    logic [SHW:0]    w_step;
    logic [XLEN-1:0] w_next;

    // Arithmetic right shifts keep bit XLEN-1 untouched, so every step refills
    // with the original sign bit.
    always_comb begin
        w_step = (r_rem > STEP) ? STEP : r_rem;
        if (!r_dir) begin
            w_next = r_data << w_step;
        end else if (r_arith) begin
            w_next = $unsigned($signed(r_data) >>> w_step);
        end else begin
            w_next = r_data >> w_step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || kill) begin
            r_data  <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_dir   <= 1'b0;
            r_arith <= 1'b0;
        end else if (start) begin
            r_data  <= data;
            r_rem   <= {1'b0, shamt};
            r_busy  <= (shamt != '0);
            r_dir   <= dir;
            r_arith <= arith;
        end else if (r_busy) begin
            r_data <= w_next;
            r_rem  <= r_rem - w_step;
            if (r_rem <= STEP) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_busy && (r_rem <= STEP);
    assign result = w_next;

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with valid/ready on both sides. Single-cycle ops complete in
// one cycle; shifts are delegated to the iterative shifter.
module alu_exec_stage #(
    parameter int XLEN       = alu_pkg::XLEN,
    parameter int SHIFT_STEP = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          operation,
    input  logic [XLEN-1:0]     src_a,
    input  logic [XLEN-1:0]     src_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     alu_result,
    output logic                br_taken,
    output alu_pkg::ex_state_t  o_dbg_state
);

    import alu_pkg::*;

    localparam int SHW = $clog2(XLEN);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; a valid offer is held stable until it is taken, and the
    // producer never waits on ready before raising valid.

    ex_state_t       r_state;
    logic            r_out_valid;
    logic [XLEN-1:0] r_alu_result;
    logic            r_br_taken;

    alu_op_t         w_op;
    logic [SHW-1:0]  w_shamt;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_is_shift;
    logic            w_shift_start;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_diff;
    logic            w_lt;
    logic            w_eq;
    logic [XLEN-1:0] w_res;
    logic            w_br;
    logic            w_sh_busy;
    logic            w_sh_done;
    logic [XLEN-1:0] w_sh_result;

    assign w_op          = alu_op_t'(operation);
    assign w_shamt       = src_b[SHW-1:0];
    assign w_is_shift    = op_is_shift(w_op);
    assign w_in_ready    = !w_sh_busy &&
                           ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
    assign w_accept      = in_valid && w_in_ready && !flush;
    assign w_shift_start = w_accept && w_is_shift && (w_shamt != '0);

    assign w_sum  = src_a + src_b;
    assign w_diff = src_a - src_b;
    assign w_lt   = $signed(src_a) < $signed(src_b);
    assign w_eq   = (src_a == src_b);

    // Shift ops reaching this path have shamt == 0, so they pass src_a through.
    always_comb begin
        w_res = '0;
        w_br  = 1'b0;
        case (w_op)
            OP_AND:           w_res = src_a & src_b;
            OP_OR:            w_res = src_a | src_b;
            OP_ADD, OP_ADDI:  w_res = w_sum;
            OP_XOR:           w_res = src_a ^ src_b;
            OP_SUB:           w_res = w_diff;
            OP_SLL, OP_SRL,
            OP_SRA:           w_res = src_a;
            OP_EQ:            w_br  = w_eq;
            OP_NE:            w_br  = !w_eq;
            OP_GE:            w_br  = !w_lt;
            OP_LT:            w_br  = w_lt;
            OP_SLT, OP_SLTI:  w_res = {{(XLEN-1){1'b0}}, w_lt};
            default:          w_res = '0;
        endcase
        if (w_op inside {OP_EQ, OP_NE, OP_GE, OP_LT}) begin
            w_res = {{(XLEN-1){1'b0}}, w_br};
        end
    end

    alu_shift_iter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift (
        .clk    (clk),
        .reset  (reset),
        .kill   (flush),
        .start  (w_shift_start),
        .dir    (w_op != OP_SLL),
        .arith  (w_op == OP_SRA),
        .data   (src_a),
        .shamt  (w_shamt),
        .busy   (w_sh_busy),
        .done   (w_sh_done),
        .result (w_sh_result)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state      <= ST_IDLE;
            r_out_valid  <= 1'b0;
            r_alu_result <= '0;
            r_br_taken   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        if (w_shift_start) begin
                            r_state     <= ST_SHIFT;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state      <= ST_DONE;
                            r_out_valid  <= 1'b1;
                            r_alu_result <= w_res;
                            r_br_taken   <= w_br;
                        end
                    end else if ((r_state == ST_DONE) && out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (w_sh_done) begin
                        r_state      <= ST_DONE;
                        r_out_valid  <= 1'b1;
                        r_alu_result <= w_sh_result;
                        r_br_taken   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign alu_result  = r_alu_result;
    assign br_taken    = r_br_taken;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: directed scenarios plus random ops under
// random back-pressure, with result, hold and latency checks.
module tb_alu_exec_stage;

    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  operation;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;
    logic        br_taken;
    ex_state_t   dbg_state;

    logic [32:0] exp_q[$];
    int          lat_q[$];
    int          acc_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;
    bit seen    = 1'b0;
    bit rand_ready = 1'b0;

    alu_exec_stage #(.XLEN(32), .SHIFT_STEP(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .operation   (operation),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .br_taken    (br_taken),
        .o_dbg_state (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: full-width shifts, independent of the iterative datapath.
    function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic        c;
        logic [31:0] r;
        int          sh;
        sh = int'(b[4:0]);
        c  = 1'b0;
        r  = 32'h0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2, 4'hD: r = a + b;
            4'h3: r = a ^ b;
            4'h4: r = a << sh;
            4'h5: r = a >> sh;
            4'h6: r = a - b;
            4'h7: r = $unsigned($signed(a) >>> sh);
            4'h8: c = (a == b);
            4'h9: c = (a != b);
            4'hA: c = ($signed(a) >= $signed(b));
            4'hB: c = ($signed(a) < $signed(b));
            4'hC, 4'hE: r = {31'h0, ($signed(a) < $signed(b))};
            default: r = 32'h0;
        endcase
        if (op >= 4'h8 && op <= 4'hB) r = {31'h0, c};
        return {c, r};
    endfunction

    function automatic int exp_latency(input logic [3:0] op, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        if ((op == 4'h4 || op == 4'h5 || op == 4'h7) && sh != 0) return 1 + (sh + 7) / 8;
        return 1;
    endfunction

    // Driver: called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [32:0] exp, input bit push);
        int waited;
        operation = op;
        src_a     = a;
        src_b     = b;
        in_valid  = 1'b1;
        waited    = 0;
        @(negedge clk);
        while (!in_ready && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
        end else if (push) begin
            exp_q.push_back(exp);
            lat_q.push_back(exp_latency(op, b));
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0;
    endtask

    // Scoreboard / monitor
    always @(negedge clk) begin
        if (!reset && mon_en) begin
            if (exp_q.size() == 0) begin
                check("no_spurious_valid", out_valid, 0);
            end else if (out_valid) begin
                if (!seen) begin
                    check("latency", cyc - acc_q[0], lat_q[0]);
                    seen = 1'b1;
                end
                check(out_ready ? "result" : "hold", {br_taken, alu_result}, exp_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(lat_q.pop_front());
                    void'(acc_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [3:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        int          waited;

        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        operation = 4'h0;
        src_a = 32'h0;
        src_b = 32'h0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_result", alu_result, 0);
        check("rst_br_taken", br_taken, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_state", dbg_state, ST_IDLE);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Single-cycle ALU ops and branches, back to back
        send(4'h6, 32'd5, 32'd7, {1'b0, 32'hFFFF_FFFE}, 1'b1);
        send(4'hC, 32'hFFFF_FFFF, 32'd1, {1'b0, 32'h1}, 1'b1);
        send(4'hB, 32'hFFFF_FFFF, 32'd1, {1'b1, 32'h1}, 1'b1);
        send(4'h8, 32'd3, 32'd4, {1'b0, 32'h0}, 1'b1);
        send(4'hF, 32'hDEAD_BEEF, 32'h1234_5678, {1'b0, 32'h0}, 1'b1);
        send(4'hA, 32'h8000_0000, 32'h1, {1'b0, 32'h0}, 1'b1);
        send(4'h4, 32'hCAFE_F00D, 32'h20, {1'b0, 32'hCAFE_F00D}, 1'b1);
        drive_idle();
        repeat (2) @(posedge clk);
        #1;

        // Long arithmetic shift: SHIFT for 4 cycles
        send(4'h7, 32'h8000_0000, 32'd31, {1'b0, 32'hFFFF_FFFF}, 1'b1);
        drive_idle();
        repeat (4) begin
            @(negedge clk);
            check("sra_in_ready_low", in_ready, 0);
        end
        @(posedge clk);
        #1;
        send(4'h4, 32'h0000_00FF, 32'd8, {1'b0, 32'h0000_FF00}, 1'b1);
        send(4'h5, 32'h8000_0000, 32'd9, {1'b0, 32'h0040_0000}, 1'b1);
        drive_idle();
        repeat (6) @(posedge clk);
        #1;

        // Back-pressure then zero-bubble acceptance in DONE
        out_ready = 1'b0;
        send(4'h2, 32'd10, 32'd20, {1'b0, 32'd30}, 1'b1);
        drive_idle();
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4'h2, 32'd2, 32'd3, {1'b0, 32'd5}, 1'b1);
        drive_idle();
        repeat (2) @(posedge clk);
        #1;

        // Flush mid-shift, with an op offered during the flush cycle
        send(4'h5, 32'hF000_0000, 32'd20, 33'h0, 1'b0);
        drive_idle();
        @(negedge clk);
        check("flush_pre_state", dbg_state, ST_SHIFT);
        @(posedge clk);
        #1;
        flush = 1'b1;
        in_valid = 1'b1;
        operation = 4'h2;
        src_a = 32'd1;
        src_b = 32'd1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_state_idle", dbg_state, ST_IDLE);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        repeat (5) @(posedge clk);
        #1;

        // Reset held 2 cycles in the middle of a shift
        send(4'h7, 32'h8000_0000, 32'd31, 33'h0, 1'b0);
        drive_idle();
        @(negedge clk);
        check("rst2_pre_state", dbg_state, ST_SHIFT);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst2_out_valid", out_valid, 0);
        check("rst2_alu_result", alu_result, 0);
        check("rst2_in_ready", in_ready, 1);
        check("rst2_state", dbg_state, ST_IDLE);
        repeat (3) @(posedge clk);
        #1;

        // Random ops under random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = $urandom;
            r_b  = $urandom;
            if ($urandom_range(0, 3) == 0) r_b = {27'h0, r_b[4:0]};
            if ($urandom_range(0, 5) == 0) r_b = r_a;
            send(r_op, r_a, r_b, model(r_op, r_a, r_b), 1'b1);
            if ($urandom_range(0, 2) == 0) drive_idle();
        end
        drive_idle();
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;

        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage ALU. Consumes the 4-bit operation code from the ALU controller plus two 32-bit operands, and produces a registered result and a branch-condition flag.
- Sits between the decode/register-read stage and the memory/writeback stage, with a valid/ready handshake on both sides.
- Single-cycle ops have latency 1. Shifts run iteratively, SHIFT_STEP bits per cycle, to keep the barrel shifter off the critical path.

Parameters:
- XLEN, 32: operand/result width.
- SHIFT_STEP, 8: maximum shift distance per cycle. Must be a power of two, 1..32.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous kill of any in-flight op
- in_valid  input  1  upstream presents an op
- in_ready  output  1  stage can accept
- operation  input  4  ALU op code from ALU controller
- src_a  input  XLEN  operand A (rs1 / PC)
- src_b  input  XLEN  operand B (rs2 / imm); shamt = src_b[4:0]
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- alu_result  output  XLEN  result
- br_taken  output  1  branch condition true (branch ops only, else 0)

Behaviour:
- Clocking and reset: single clock domain; synchronous, active-high reset.
- Op decode:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 SLL; 0101 SRL; 0110 SUB; 0111 SRA.
  - 1000 EQ; 1001 NE; 1010 GE (signed); 1011 LT (signed).
  - 1100 SLT; 1101 ADD (ADDI); 1110 SLT (SLTI).
  - 1111 reserved: result 0, br_taken 0, latency 1.
- Arithmetic is modulo 2^XLEN, with no overflow flag.
- SLT/LT/GE use signed compare; the SLT result is zero-extended 0/1.
- Branch ops (1000–1011): alu_result = {31'b0, cond} and br_taken = cond.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready = 1. On in_valid, latch the inputs.
    - Non-shift op, or shift with shamt = 0: compute and go to DONE.
    - Shift with shamt != 0: load the shift register with src_a, set remaining = shamt, go to SHIFT.
  - SHIFT: in_ready = 0. Each cycle, shift by min(remaining, SHIFT_STEP) and subtract that from remaining. SRA fills with the original bit 31; SLL/SRL fill with 0. When remaining reaches 0, go to DONE.
  - DONE: out_valid = 1, and alu_result/br_taken are held stable until out_ready.
    - out_ready = 1 and in_valid = 1: accept the new op in the same cycle (in_ready = out_ready). Go to SHIFT or stay in DONE per the new op.
    - out_ready = 1 and in_valid = 0: go to IDLE.
- Latency, counted from the acceptance cycle to the first out_valid cycle:
  - Non-shift ops: 1.
  - Shift ops: 1 + ceil(shamt / SHIFT_STEP). Worst case at the default step is 5 (shamt 31).
- Throughput: one op per cycle for non-shift ops under continuous out_ready.
- Reset and flush: both force IDLE and clear the shift state. Reset values are out_valid = 0, alu_result = 0, br_taken = 0, in_ready = 1.
  - Flush in any state takes effect the following cycle. Any op offered in the same cycle is discarded.
  - Reset and flush asserted together: reset wins (same effect).
- Outputs come straight from registers, with no combinational input→output paths except in_ready, which depends on out_ready in DONE.

Decomposition:
- Shared package `alu_pkg`:
  - XLEN;
  - the `alu_op_t` enum for the 16 codes, which the ALU controller also uses;
  - the `ex_state_t` enum {IDLE, SHIFT, DONE}.
- Natural sub-module `alu_shift_iter`, the iterative shifter:
  - inputs: start, dir, arith, data, shamt;
  - outputs: busy, done, result.

Test Plan:
- Reset: reset = 1 for 2 cycles mid-SHIFT → out_valid = 0, alu_result = 0, in_ready = 1 the next cycle.
- ALU ops: SUB (0110) with 5, 7 → 0xFFFFFFFE one cycle after acceptance. SLT (1100) with 0xFFFFFFFF, 1 → 1.
- Branches: LT (1011) with 0xFFFFFFFF, 1 → br_taken = 1, result 1. EQ (1000) with 3, 4 → br_taken = 0.
- Long arithmetic shift: SRA (0111) with 0x80000000, shamt 31, SHIFT_STEP 8 → 0xFFFFFFFF at latency 5, in_ready = 0 for 4 cycles. SLL with shamt 0 → src_a at latency 1.
- Back-pressure: out_ready held low 3 cycles in DONE → alu_result stable, in_ready = 0. Then out_ready = 1 with in_valid = 1 (ADD 2, 3) → next result 5 the following cycle, with no bubble.
- Flush and reserved code: flush during SHIFT (SRL 0xF0000000 by 20) → no out_valid, IDLE the next cycle. Reserved 1111 → result 0, br_taken 0.
